// File: rtl/sw_debounce.sv
// Slide-switch conditioner: two-flop synchronizer plus a per-bit debounce counter.
// It produces one-cycle edge pulses and a single-entry change-event port that keeps only the latest value.
module sw_debounce #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_data,
    output logic             evt_overflow,
    input  logic             ovf_clr
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt       [WIDTH];
    logic [CNT_W-1:0] cnt_nxt_c [WIDTH];
    logic [WIDTH-1:0] flip_c;
    logic [WIDTH-1:0] stable_nxt_c;
    logic             change_c;
    logic             coalesce_c;

    // Per-bit debounce: count consecutive disagreeing cycles and flip on the last one.
    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            flip_c[i]    = 1'b0;
            cnt_nxt_c[i] = cnt[i];
            if (sync2[i] == sw_stable[i]) begin
                cnt_nxt_c[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                flip_c[i]    = 1'b1;
                cnt_nxt_c[i] = '0;
            end else begin
                cnt_nxt_c[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    assign stable_nxt_c = sw_stable ^ flip_c;
    assign change_c     = |flip_c;
    assign coalesce_c   = change_c & evt_valid & ~evt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            sw_stable <= '0;
            sw_rise   <= '0;
            sw_fall   <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1     <= sw_raw;
            sync2     <= sync1;
            sw_stable <= stable_nxt_c;
            sw_rise   <= flip_c & ~sw_stable;
            sw_fall   <= flip_c & sw_stable;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt_c[i];
            end
        end
    end

    // Event slot: a new change always overwrites it; a transfer empties it only when no change arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid    <= 1'b0;
            evt_data     <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (change_c) begin
                evt_valid <= 1'b1;
                evt_data  <= stable_nxt_c;
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end

            if (coalesce_c) begin
                evt_overflow <= 1'b1;
            end else if (ovf_clr) begin
                evt_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input-side conditioner for the board slide switches: the producer end of the raw-switch path that top-level logic consumes.
- Synchronizes and debounces each raw switch bit, then publishes the clean value.
- Emits one-cycle rise/fall pulses per bit.
- Reports every change of the clean value through a single-entry valid/ready event port that holds only the latest value.

Parameters:
- WIDTH, 8, number of switch bits.
- DEBOUNCE_CYCLES, 50000, consecutive cycles a synchronized bit must differ from its stable value before the stable value flips. Must be >= 1.
- CNT_W, 16, per-bit counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sw_raw  input  WIDTH  raw switch pins, asynchronous to clk.
- sw_stable  output  WIDTH  debounced switch value.
- sw_rise  output  WIDTH  one-cycle pulse per bit when sw_stable bit goes 0->1.
- sw_fall  output  WIDTH  one-cycle pulse per bit when sw_stable bit goes 1->0.
- evt_valid  output  1  change event pending.
- evt_ready  input  1  consumer accepts event.
- evt_data  output  WIDTH  sw_stable value carried by the pending event.
- evt_overflow  output  1  sticky flag: a change was coalesced while an event was pending.
- ovf_clr  input  1  synchronous clear of evt_overflow.

Behaviour:
- Reset:
  - Asynchronous, active-low; takes effect immediately, with no clock edge needed.
  - While rst_n=0, all registers are 0: sync stages, counters, sw_stable, sw_rise, sw_fall, evt_valid, evt_data, evt_overflow.
  - Reset mid-count discards all partial counts.
  - After release, any raw bits that are high are debounced normally and produce rise pulses and an event.
- Synchronizer: two flops per bit (sync1 <= sw_raw, sync2 <= sync1). Only sync2 is used downstream.
- Per-bit debounce:
  - On each edge where sync2[i]==sw_stable[i], cnt[i] <= 0.
  - On each edge where they differ and cnt[i] < DEBOUNCE_CYCLES-1, cnt[i] <= cnt[i]+1.
  - On the edge where they differ and cnt[i]==DEBOUNCE_CYCLES-1, sw_stable[i] <= sync2[i] and cnt[i] <= 0.
  - Any return to equality before the flip edge resets the count, so glitches shorter than DEBOUNCE_CYCLES synchronized cycles are fully rejected.
- Latency: a raw value first sampled into sync1 at edge N appears on sw_stable after edge N+DEBOUNCE_CYCLES+1.
  - That is DEBOUNCE_CYCLES+2 edges counting N.
  - Example: DEBOUNCE_CYCLES=4, sampled at edge 1, sw_stable updates at edge 6.
- Edge pulses:
  - sw_rise[i] and sw_fall[i] are registered and high exactly for the cycle following the flip edge; otherwise 0.
  - Several bits may pulse in the same cycle.
- Event port:
  - A "change" is any edge on which at least one sw_stable bit flips.
  - On a change: evt_valid <= 1 and evt_data <= the new sw_stable value.
  - Transfer occurs on an edge with evt_valid && evt_ready.
  - Transfer without a change on that edge: evt_valid <= 0, and evt_data is held.
  - Transfer and change on the same edge: evt_valid stays 1, evt_data <= new value, and no overflow is flagged.
  - Change while evt_valid=1 and evt_ready=0: evt_data <= new value (coalesced) and evt_overflow <= 1.
  - evt_data therefore may change while valid only in the coalescing case. The consumer always ends with the latest value.
  - evt_ready while evt_valid=0 has no effect.
- Overflow flag:
  - ovf_clr=1 clears evt_overflow on the next edge.
  - If a coalesce occurs on the same edge as ovf_clr, set wins and evt_overflow stays 1.
- DEBOUNCE_CYCLES=1 degenerates to sync-only: stable follows sync2 with one edge of lag.

Test Plan:
All scenarios use WIDTH=8, DEBOUNCE_CYCLES=4 and evt_ready=0 unless stated.
1. Release reset, drive sw_raw=0xA5 before edge 1 -> sw_stable=0x00 through edge 5 and 0xA5 after edge 6; sw_rise=0xA5 for exactly one cycle; sw_fall=0x00; evt_valid=1, evt_data=0xA5, evt_overflow=0.
2. From stable 0x00, pulse sw_raw[0]=1 for 3 cycles then 0 -> sw_stable stays 0x00; no rise/fall pulse; evt_valid stays 0.
3. After scenario 1, raise evt_ready for one cycle -> evt_valid=0 after that edge, evt_data holds 0xA5, no overflow.
4. Event 0xA5 pending, then sw_raw=0xA4 and settle -> evt_valid=1, evt_data=0xA4, evt_overflow=1, sw_fall=0x01 pulse; assert ovf_clr for one cycle -> evt_overflow=0, evt_valid still 1.
5. Schedule evt_ready=1 on the exact edge where sw_stable flips 0xA5->0x25 -> evt_valid remains 1, evt_data=0x25, evt_overflow=0.
6. Drop rst_n mid-count (counter=2), between clock edges -> all outputs 0 immediately. Release with sw_raw=0x01 -> sw_stable=0x01 exactly DEBOUNCE_CYCLES+2 edges after the first sampling edge.
